shift_seq32: RTL and testbench

Sequencing front-end for the 32-bit combinational barrel shifter (`shifter32`: `din`, `shamt`, `LR`, `AL` → `dout`). It accepts shift and rotate operations over a valid/ready request channel and drives the shifter from registered controls. Rotates run as two shifter passes OR-ed together. The result is held on a valid/ready result channel. It sits directly upstream of `shifter32` and owns its inputs.

---
 rtl/shift_seq32.sv | 161 ++++++++++++++++
 tb/tb_shift_seq32.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq32.sv
`default_nettype none
// ============================================================================
// Module   : shift_seq32
// Brief    : Valid/ready sequencer driving a 32-bit combinational shifter;
//            rotates are built from two OR-ed shifter passes.
// Revision : 1.0 - initial release
// ============================================================================
module shift_seq32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [31:0] in_data,
    input  logic [4:0]  in_shamt,
    output logic [31:0] sh_din,
    output logic [4:0]  sh_shamt,
    output logic        sh_LR,
    output logic        sh_AL,
    input  logic [31:0] sh_dout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);

    localparam logic [2:0] c_OP_SLL = 3'b000;
    localparam logic [2:0] c_OP_SRL = 3'b001;
    localparam logic [2:0] c_OP_SRA = 3'b010;
    localparam logic [2:0] c_OP_ROL = 3'b011;
    localparam logic [2:0] c_OP_ROR = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PASS1 = 2'd1,
        S_PASS2 = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [2:0]  r_op;
    logic [31:0] r_data;
    logic [4:0]  r_shamt;
    logic [31:0] r_acc;
    logic [4:0]  r_sh_shamt;
    logic        r_sh_lr;
    logic        r_sh_al;

    logic        w_accept;
    logic        w_need_pass2;
    logic [4:0]  w_p1_shamt;
    logic        w_p1_lr;
    logic        w_p1_al;
    logic [4:0]  w_p2_shamt;
    logic        w_p2_lr;

    // Pass-1 controls are decoded from the incoming request so they can be
    // registered on the accepting edge.
    always_comb begin
        w_p1_shamt = in_shamt;
        w_p1_lr    = 1'b1;
        w_p1_al    = 1'b0;
        case (in_op)
            c_OP_SLL, c_OP_ROL: w_p1_lr = 1'b1;
            c_OP_SRL, c_OP_ROR: w_p1_lr = 1'b0;
            c_OP_SRA: begin
                w_p1_lr = 1'b0;
                w_p1_al = 1'b1;
            end
            default:            w_p1_shamt = 5'd0;
        endcase
    end

    // Second pass shifts the opposite way by (32 - n) mod 32.
    assign w_p2_shamt   = 5'd0 - r_shamt;
    assign w_p2_lr      = (r_op == c_OP_ROR);
    assign w_need_pass2 = ((r_op == c_OP_ROL) || (r_op == c_OP_ROR)) && (r_shamt != 5'd0);
    assign w_accept     = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_PASS1;
                end
            end
            S_PASS1: begin
                w_state_nxt = w_need_pass2 ? S_PASS2 : S_DONE;
            end
            S_PASS2: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op       <= 3'd0;
            r_data     <= 32'd0;
            r_shamt    <= 5'd0;
            r_acc      <= 32'd0;
            r_sh_shamt <= 5'd0;
            r_sh_lr    <= 1'b0;
            r_sh_al    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op       <= in_op;
                        r_data     <= in_data;
                        r_shamt    <= in_shamt;
                        r_sh_shamt <= w_p1_shamt;
                        r_sh_lr    <= w_p1_lr;
                        r_sh_al    <= w_p1_al;
                    end
                end
                S_PASS1: begin
                    r_acc <= sh_dout;
                    if (w_need_pass2) begin
                        r_sh_shamt <= w_p2_shamt;
                        r_sh_lr    <= w_p2_lr;
                        r_sh_al    <= 1'b0;
                    end
                end
                S_PASS2: begin
                    r_acc <= r_acc | sh_dout;
                end
                default: begin
                end
            endcase
        end
    end

    assign sh_din   = r_data;
    assign sh_shamt = r_sh_shamt;
    assign sh_LR    = r_sh_lr;
    assign sh_AL    = r_sh_al;
    assign out_data = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_shift_seq32.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_seq32
// Brief    : Self-checking bench for shift_seq32 with a behavioural shifter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_seq32;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [31:0] sh_din;
    logic [4:0]  sh_shamt;
    logic        sh_LR;
    logic        sh_AL;
    logic [31:0] sh_dout;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int n_cmp  = 0;
    int n_fail = 0;

    shift_seq32 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .sh_din    (sh_din),
        .sh_shamt  (sh_shamt),
        .sh_LR     (sh_LR),
        .sh_AL     (sh_AL),
        .sh_dout   (sh_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    // Downstream combinational shifter32
    logic signed [31:0] w_sdin;
    assign w_sdin = sh_din;
    always_comb begin
        if (sh_LR)      sh_dout = sh_din << sh_shamt;
        else if (sh_AL) sh_dout = w_sdin >>> sh_shamt;
        else            sh_dout = sh_din >> sh_shamt;
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] data;
        logic [4:0]  n;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [0:8];

    function automatic logic [31:0] ref_model(logic [2:0] op, logic [31:0] x, logic [4:0] n);
        logic [63:0] d;
        logic [31:0] r;
        case (op)
            3'd0: r = x << n;
            3'd1: r = x >> n;
            3'd2: begin d = {{32{x[31]}}, x} >> n; r = d[31:0];  end
            3'd3: begin d = {x, x} << n;           r = d[63:32]; end
            3'd4: begin d = {x, x} >> n;           r = d[31:0];  end
            default: r = x;
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_op(logic [2:0] op, logic [31:0] data, logic [4:0] n,
                         logic [31:0] exp, int lat, int delay);
        int  cnt;
        int  guard;
        logic rot;
        rot      = (op == 3'd3) || (op == 3'd4);
        in_op    = op;
        in_data  = data;
        in_shamt = n;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        check32("accept_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check32("p1_din",   sh_din, data);
        check32("p1_LR",    32'(sh_LR), 32'((op == 3'd0) || (op == 3'd3) || (op >= 3'd5)));
        check32("p1_AL",    32'(sh_AL), 32'(op == 3'd2));
        check32("p1_shamt", 32'(sh_shamt), (op >= 3'd5) ? 32'd0 : 32'(n));
        cnt = 1;
        while (!out_valid && cnt < 10) begin
            tick();
            cnt++;
            if (cnt == 2 && rot && n != 5'd0) begin
                check32("p2_shamt", 32'(sh_shamt), 32'((32 - int'(n)) % 32));
                check32("p2_LR",    32'(sh_LR), 32'(op == 3'd4));
                check32("p2_AL",    32'(sh_AL), 32'd0);
            end
        end
        check32("latency",   32'(cnt), 32'(lat));
        check32("out_valid", 32'(out_valid), 32'd1);
        check32("out_data",  out_data, exp);
        repeat (delay) tick();
        check32("held_data", out_data, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check32("post_valid", 32'(out_valid), 32'd0);
        check32("post_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{3'd0, 32'hAAAAAAAA, 5'd2,  32'hAAAAAAA8, 2};
        vecs[1] = '{3'd1, 32'hAAAAAAAA, 5'd2,  32'h2AAAAAAA, 2};
        vecs[2] = '{3'd2, 32'hFFFFFFFA, 5'd2,  32'hFFFFFFFE, 2};
        vecs[3] = '{3'd2, 32'h7FFFFFF0, 5'd4,  32'h07FFFFFF, 2};
        vecs[4] = '{3'd3, 32'h80000001, 5'd4,  32'h00000018, 3};
        vecs[5] = '{3'd4, 32'h00000001, 5'd1,  32'h80000000, 3};
        vecs[6] = '{3'd3, 32'h12345678, 5'd0,  32'h12345678, 2};
        vecs[7] = '{3'd7, 32'hDEADBEEF, 5'd9,  32'hDEADBEEF, 2};
        vecs[8] = '{3'd4, 32'hF0000000, 5'd31, 32'hE0000001, 3};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in_data   = 32'd0;
        in_shamt  = 5'd0;
        out_ready = 1'b0;
        repeat (2) tick();
        check32("rst_in_ready",  32'(in_ready), 32'd1);
        check32("rst_out_valid", 32'(out_valid), 32'd0);
        check32("rst_out_data",  out_data, 32'd0);
        check32("rst_sh_din",    sh_din, 32'd0);
        check32("rst_sh_ctl",    {25'd0, sh_shamt, sh_LR, sh_AL}, 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].op, vecs[i].data, vecs[i].n, vecs[i].exp, vecs[i].lat, i % 3);
        end

        // Backpressure with a new request pending while the result is held
        in_op = 3'd0; in_data = 32'h0000000F; in_shamt = 5'd4; in_valid = 1'b1;
        tick();
        in_op = 3'd1; in_data = 32'h80000000; in_shamt = 5'd31;
        tick();
        for (int i = 0; i < 5; i++) begin
            check32("bp_valid",  32'(out_valid), 32'd1);
            check32("bp_data",   out_data, 32'h000000F0);
            check32("bp_ready",  32'(in_ready), 32'd0);
            check32("bp_sh_din", sh_din, 32'h0000000F);
            check32("bp_sh_ctl", {25'd0, sh_shamt, sh_LR, sh_AL}, {25'd0, 5'd4, 1'b1, 1'b0});
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check32("bp_idle_ready", 32'(in_ready), 32'd1);
        check32("bp_not_taken",  sh_din, 32'h0000000F);
        tick();
        in_valid = 1'b0;
        check32("bp_new_din",   sh_din, 32'h80000000);
        check32("bp_new_shamt", 32'(sh_shamt), 32'd31);
        tick();
        check32("bp_new_valid", 32'(out_valid), 32'd1);
        check32("bp_new_data",  out_data, 32'h00000001);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset while a rotate is in its second pass
        in_op = 3'd4; in_data = 32'h00001234; in_shamt = 5'd8; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check32("mid_p2_shamt", 32'(sh_shamt), 32'd24);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check32("mid_rst_valid", 32'(out_valid), 32'd0);
        check32("mid_rst_ready", 32'(in_ready), 32'd1);
        check32("mid_rst_din",   sh_din, 32'd0);
        check32("mid_rst_ctl",   {25'd0, sh_shamt, sh_LR, sh_AL}, 32'd0);
        check32("mid_rst_data",  out_data, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check32("mid_rst_no_out", 32'(out_valid), 32'd0);
        end
        do_op(3'd0, 32'h00000001, 5'd31, 32'h80000000, 2, 0);

        // Randomized operations against the reference model
        for (int i = 0; i < 150; i++) begin
            logic [2:0]  op;
            logic [31:0] x;
            logic [4:0]  n;
            int          lat;
            op  = 3'($urandom_range(0, 7));
            x   = $urandom;
            n   = 5'($urandom_range(0, 31));
            lat = (((op == 3'd3) || (op == 3'd4)) && n != 5'd0) ? 3 : 2;
            do_op(op, x, n, ref_model(op, x, n), lat, int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
